// File: rtl/regfile_wb_pkg.sv
// Shared definitions for the register-file write-back scheduler.
// Holds the FSM state type, RegWrite encodings, requester indices and
// default widths used by regfile_wb_sched and wb_rr_arbiter.
package regfile_wb_pkg;

  // Default widths for a 16 x 16-bit register file.
  localparam int DW_DEF = 16;
  localparam int AW_DEF = 4;

  // Write-back FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_GP = 2'd1,
    WR_LO = 2'd2,
    WR_HI = 2'd3
  } wb_state_t;

  // RegWrite encodings seen by the register file. 2'b11 is never driven.
  localparam logic [1:0] RW_NONE = 2'b00;
  localparam logic [1:0] RW_GP   = 2'b01;
  localparam logic [1:0] RW_R15  = 2'b10;

  // Requester indices into the request/grant vectors.
  localparam logic [1:0] REQ_ALU = 2'd0;
  localparam logic [1:0] REQ_MEM = 2'd1;
  localparam logic [1:0] REQ_MD  = 2'd2;

  // Rotation order ALU -> MEM -> MD -> ALU.
  function automatic logic [1:0] next_req(input logic [1:0] r);
    logic [1:0] n;
    n = (r == REQ_MD) ? REQ_ALU : r + 2'd1;
    return n;
  endfunction

endpackage

// File: rtl/regfile_wb_sched_arb.sv
// wb_rr_arbiter: 3-way one-hot grant for the write-back port.
// With RR_ARB_EN defined the highest-priority requester rotates so the
// last-granted requester drops to lowest priority; the rotation pointer
// only moves on a real grant. Without RR_ARB_EN the arbiter is purely
// combinational fixed priority MD > MEM > ALU.
// When en is low (WR_LO or reset) no grant is issued.
import regfile_wb_pkg::*;

module wb_rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] req,
  output logic [2:0] grant
);

`ifdef RR_ARB_EN
  // Index of the requester currently holding highest priority.
  logic [1:0] top_q;

  // Search the requests starting at the current top-priority requester.
  always_comb begin
    grant = 3'b000;
    if (en) begin
      case (top_q)
        REQ_MEM: begin
          if (req[REQ_MEM])      grant[REQ_MEM] = 1'b1;
          else if (req[REQ_MD])  grant[REQ_MD]  = 1'b1;
          else if (req[REQ_ALU]) grant[REQ_ALU] = 1'b1;
        end
        REQ_MD: begin
          if (req[REQ_MD])       grant[REQ_MD]  = 1'b1;
          else if (req[REQ_ALU]) grant[REQ_ALU] = 1'b1;
          else if (req[REQ_MEM]) grant[REQ_MEM] = 1'b1;
        end
        default: begin
          if (req[REQ_ALU])      grant[REQ_ALU] = 1'b1;
          else if (req[REQ_MEM]) grant[REQ_MEM] = 1'b1;
          else if (req[REQ_MD])  grant[REQ_MD]  = 1'b1;
        end
      endcase
    end
  end

  // After a grant the requester just served becomes lowest priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      top_q <= REQ_ALU;
    end else if (grant[REQ_MD]) begin
      top_q <= next_req(REQ_MD);
    end else if (grant[REQ_MEM]) begin
      top_q <= next_req(REQ_MEM);
    end else if (grant[REQ_ALU]) begin
      top_q <= next_req(REQ_ALU);
    end
  end
`else
  // Fixed priority has no state, so the clock and reset go unused here.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  // Fixed priority: MD first, then MEM, then ALU.
  always_comb begin
    grant = 3'b000;
    if (en) begin
      if (req[REQ_MD])       grant[REQ_MD]  = 1'b1;
      else if (req[REQ_MEM]) grant[REQ_MEM] = 1'b1;
      else if (req[REQ_ALU]) grant[REQ_ALU] = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched: write-back scheduler for the 16x16 register file.
// Arbitrates the ALU, load unit and multiply/divide unit onto the single
// write port. A multiply/divide result takes two cycles: low word to Rd,
// then high word to R15. All register-file outputs are registered; the
// ready outputs are combinational from state, arbiter and valids.
// Build option: RR_ARB_EN selects round-robin arbitration (default is
// fixed priority MD > MEM > ALU).
import regfile_wb_pkg::*;

module regfile_wb_sched #(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_rd,
  input  logic [DW-1:0] alu_data,
  output logic          alu_ready,
  input  logic          mem_valid,
  input  logic [AW-1:0] mem_rd,
  input  logic [DW-1:0] mem_data,
  output logic          mem_ready,
  input  logic          md_valid,
  input  logic [AW-1:0] md_rd,
  input  logic [DW-1:0] md_lo,
  input  logic [DW-1:0] md_hi,
  output logic          md_ready,
  output logic [1:0]    RegWrite,
  output logic [AW-1:0] WriteReg,
  output logic [DW-1:0] WriteData,
  output logic [DW-1:0] WriteR15,
  output logic          busy
);

  wb_state_t     state_q, state_d;
  logic [2:0]    req, grant;
  logic          arb_en;
  logic [1:0]    rw_q, rw_d;
  logic [AW-1:0] wreg_q, wreg_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] wr15_q, wr15_d;
  logic [DW-1:0] hi_q;

  // Request vector in requester-index order.
  assign req[REQ_ALU] = alu_valid;
  assign req[REQ_MEM] = mem_valid;
  assign req[REQ_MD]  = md_valid;

  // The port is spoken for while the low word is out, and nothing is
  // accepted while reset is held.
  assign arb_en = rst && (state_q != WR_LO);

  wb_rr_arbiter u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (arb_en),
    .req   (req),
    .grant (grant)
  );

  assign alu_ready = grant[REQ_ALU];
  assign mem_ready = grant[REQ_MEM];
  assign md_ready  = grant[REQ_MD];

  // Next state and next register-file outputs; unused fields stay zero.
  always_comb begin
    state_d = IDLE;
    rw_d    = RW_NONE;
    wreg_d  = '0;
    wdata_d = '0;
    wr15_d  = '0;
    if (state_q == WR_LO) begin
      state_d = WR_HI;
      rw_d    = RW_R15;
      wr15_d  = hi_q;
    end else if (grant[REQ_MD]) begin
      state_d = WR_LO;
      rw_d    = RW_GP;
      wreg_d  = md_rd;
      wdata_d = md_lo;
    end else if (grant[REQ_MEM]) begin
      state_d = WR_GP;
      rw_d    = RW_GP;
      wreg_d  = mem_rd;
      wdata_d = mem_data;
    end else if (grant[REQ_ALU]) begin
      state_d = WR_GP;
      rw_d    = RW_GP;
      wreg_d  = alu_rd;
      wdata_d = alu_data;
    end
  end

  // State and registered outputs; reset drops any pending R15 write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rw_q    <= RW_NONE;
      wreg_q  <= '0;
      wdata_q <= '0;
      wr15_q  <= '0;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      wr15_q  <= wr15_d;
    end
  end

  // Hold the high word from acceptance until the WR_HI cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
    end else if (grant[REQ_MD]) begin
      hi_q <= md_hi;
    end
  end

  assign RegWrite  = rw_q;
  assign WriteReg  = wreg_q;
  assign WriteData = wdata_q;
  assign WriteR15  = wr15_q;
  assign busy      = (state_q != IDLE);

endmodule
